bsg_fifo_to_dfi: RTL and testbench

Transmit-side bridge that drains a DDR command FIFO and a write-data FIFO onto a DFI interface, and pushes returned DFI read data into a read FIFO. It runs on a single fast clock that is `clk_ratio_p` times the DFI 1x rate. Every DFI output is held for exactly `clk_ratio_p` cycles per DFI slot, so a DFI-sampling receiver in that clock domain sees one word per slot. It sits between the memory-controller command queues and the DFI/PHY boundary.

---
 rtl/bsg_fifo_to_dfi.sv | 162 ++++++++++++++++
 tb/tb_bsg_fifo_to_dfi.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fifo_to_dfi.sv
// Command/write FIFO drain onto DFI, plus DFI read return into a read FIFO.
// Pops/pushes are combinational in the phase-0 cycle; DFI outputs register on the edge ending phase 0 and hold one slot.
// Read FIFO not-ready drops data and flags error_o; 255 outstanding reads stall further read commands.
// Optional macro BSG_FIFO_TO_DFI_STICKY_ERROR_EN: error_o holds until reset instead of pulsing.
module bsg_fifo_to_dfi #(
  parameter int clk_ratio_p     = 4,
  parameter int dq_data_width_p = 16,
  parameter int rd_en_delay_p   = 0
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic                                         cmd_v_i,
  input  logic [25:0]                                  cmd_data_i,
  output logic                                         cmd_yumi_o,
  input  logic                                         wr_v_i,
  input  logic [2*dq_data_width_p+2*(dq_data_width_p>>3)-1:0] wr_data_i,
  output logic                                         wr_yumi_o,
  output logic                                         rd_v_o,
  output logic [2*dq_data_width_p-1:0]                 rd_data_o,
  input  logic                                         rd_ready_i,
  output logic [2:0]                                   dfi_bank_o,
  output logic [15:0]                                  dfi_address_o,
  output logic                                         dfi_cke_o,
  output logic                                         dfi_cs_n_o,
  output logic                                         dfi_ras_n_o,
  output logic                                         dfi_cas_n_o,
  output logic                                         dfi_we_n_o,
  output logic                                         dfi_reset_n_o,
  output logic                                         dfi_odt_o,
  output logic                                         dfi_wrdata_en_o,
  output logic [2*dq_data_width_p-1:0]                 dfi_wrdata_o,
  output logic [2*(dq_data_width_p>>3)-1:0]            dfi_wrdata_mask_o,
  output logic                                         dfi_rddata_en_o,
  input  logic [2*dq_data_width_p-1:0]                 dfi_rddata_i,
  input  logic                                         dfi_rddata_valid_i,
  output logic                                         error_o
);

  localparam int dq_group_lp = dq_data_width_p >> 3;
  localparam int wd_lp       = 2 * dq_data_width_p;
  localparam int mw_lp       = 2 * dq_group_lp;

  logic [7:0] phase_r;
  logic       phase0;
  logic [7:0] outstanding_r;
  logic       cmd_is_rd;
  logic       stall;
  logic       rd_pop;
  logic       rd_en_next;
  logic       err_event;

  assign phase0 = (phase_r == 8'd0);

  // Read command: cs_n=0, ras_n=1, cas_n=0, we_n=1 (bits 5..2 of the command word)
  assign cmd_is_rd = ~cmd_data_i[5] & cmd_data_i[4] & ~cmd_data_i[3] & cmd_data_i[2];
  assign stall     = (outstanding_r == 8'hFF) & cmd_is_rd;

  assign cmd_yumi_o = phase0 & ~reset_i & cmd_v_i & ~stall;
  assign wr_yumi_o  = phase0 & ~reset_i & wr_v_i;
  assign rd_v_o     = phase0 & ~reset_i & dfi_rddata_valid_i;
  assign rd_data_o  = dfi_rddata_i;
  assign rd_pop     = cmd_yumi_o & cmd_is_rd;

  // A returned slot is an error if the read FIFO cannot take it or no read was outstanding
  assign err_event  = rd_v_o & (~rd_ready_i | (outstanding_r == 8'd0));

  // Phase counter wraps every clk_ratio_p cycles (stays 0 when the ratio is 1)
  always_ff @(posedge clk_i) begin
    if (reset_i || phase_r == 8'(clk_ratio_p - 1))
      phase_r <= 8'd0;
    else
      phase_r <= phase_r + 8'd1;
  end

  // Command slot: load on pop, otherwise NOP with cke/reset_n/odt/bank/address held
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dfi_bank_o    <= 3'd0;
      dfi_address_o <= 16'd0;
      dfi_cke_o     <= 1'b0;
      dfi_cs_n_o    <= 1'b1;
      dfi_ras_n_o   <= 1'b1;
      dfi_cas_n_o   <= 1'b1;
      dfi_we_n_o    <= 1'b1;
      dfi_reset_n_o <= 1'b0;
      dfi_odt_o     <= 1'b0;
    end else if (cmd_yumi_o) begin
      {dfi_bank_o, dfi_address_o, dfi_cke_o, dfi_cs_n_o, dfi_ras_n_o,
       dfi_cas_n_o, dfi_we_n_o, dfi_reset_n_o, dfi_odt_o} <= cmd_data_i;
    end else if (phase0) begin
      dfi_cs_n_o  <= 1'b1;
      dfi_ras_n_o <= 1'b1;
      dfi_cas_n_o <= 1'b1;
      dfi_we_n_o  <= 1'b1;
    end
  end

  // Write slot: enable follows the pop; data and mask hold between writes
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dfi_wrdata_en_o   <= 1'b0;
      dfi_wrdata_o      <= '0;
      dfi_wrdata_mask_o <= '0;
    end else if (phase0) begin
      dfi_wrdata_en_o <= wr_yumi_o;
      if (wr_yumi_o) begin
        dfi_wrdata_o      <= wr_data_i[wd_lp+mw_lp-1:mw_lp];
        dfi_wrdata_mask_o <= wr_data_i[mw_lp-1:0];
      end
    end
  end

  generate
    if (rd_en_delay_p == 0) begin : g_no_delay
      assign rd_en_next = rd_pop;
    end else begin : g_delay
      logic [rd_en_delay_p-1:0] rd_sr_r;
      // Slot-granular shift register carrying read pops toward the read-enable slot
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          rd_sr_r <= '0;
        end else if (phase0) begin
          rd_sr_r[0] <= rd_pop;
          for (int i = 1; i < rd_en_delay_p; i++)
            rd_sr_r[i] <= rd_sr_r[i-1];
        end
      end
      assign rd_en_next = rd_sr_r[rd_en_delay_p-1];
    end
  endgenerate

  // Read-enable output, updated once per slot
  always_ff @(posedge clk_i) begin
    if (reset_i)
      dfi_rddata_en_o <= 1'b0;
    else if (phase0)
      dfi_rddata_en_o <= rd_en_next;
  end

  // Outstanding reads: +1 per read pop, -1 per returned slot, floor at 0
  always_ff @(posedge clk_i) begin
    if (reset_i)
      outstanding_r <= 8'd0;
    else if (rd_pop && !rd_v_o)
      outstanding_r <= outstanding_r + 8'd1;
    else if (!rd_pop && rd_v_o && outstanding_r != 8'd0)
      outstanding_r <= outstanding_r - 8'd1;
  end

  // Error flag: one-cycle pulse, or sticky until reset when the macro is defined
  always_ff @(posedge clk_i) begin
    if (reset_i)
      error_o <= 1'b0;
    else
`ifdef BSG_FIFO_TO_DFI_STICKY_ERROR_EN
      error_o <= error_o | err_event;
`else
      error_o <= err_event;
`endif
  end

endmodule

// File: tb/tb_bsg_fifo_to_dfi.sv
// Scoreboard bench for bsg_fifo_to_dfi: slot-level driver with a behavioural model,
// independent negedge monitor comparing handshakes, DFI outputs and error_o every cycle.
// Inputs are randomised in non-phase-0 cycles to show they are ignored there.
module tb_bsg_fifo_to_dfi;
  localparam int CR = 4;
  localparam int DW = 16;
  localparam int D  = 2;
  localparam int WD = 2 * DW;
  localparam int MW = 2 * (DW >> 3);
`ifdef BSG_FIFO_TO_DFI_STICKY_ERROR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  bank;
    logic [15:0] addr;
    logic cke, cs_n, ras_n, cas_n, we_n, reset_n, odt;
  } cmd_t;

  typedef struct {
    logic cy, wy, rv;
    logic [WD-1:0] rdat;
    logic [63:0] dfi;
    logic e1, erest;
  } rec_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic cmd_v_i = 1'b0, wr_v_i = 1'b0, rd_ready_i = 1'b1, dfi_rddata_valid_i = 1'b0;
  logic [25:0] cmd_data_i = '0;
  logic [WD+MW-1:0] wr_data_i = '0;
  logic [WD-1:0] dfi_rddata_i = '0;
  logic cmd_yumi_o, wr_yumi_o, rd_v_o, error_o;
  logic [WD-1:0] rd_data_o, dfi_wrdata_o;
  logic [MW-1:0] dfi_wrdata_mask_o;
  logic [2:0] dfi_bank_o;
  logic [15:0] dfi_address_o;
  logic dfi_cke_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_reset_n_o, dfi_odt_o;
  logic dfi_wrdata_en_o, dfi_rddata_en_o;

  always #5 clk = ~clk;

  bsg_fifo_to_dfi #(.clk_ratio_p(CR), .dq_data_width_p(DW), .rd_en_delay_p(D)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_data_i(cmd_data_i), .cmd_yumi_o(cmd_yumi_o),
    .wr_v_i(wr_v_i), .wr_data_i(wr_data_i), .wr_yumi_o(wr_yumi_o),
    .rd_v_o(rd_v_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .dfi_bank_o(dfi_bank_o), .dfi_address_o(dfi_address_o),
    .dfi_cke_o(dfi_cke_o), .dfi_cs_n_o(dfi_cs_n_o), .dfi_ras_n_o(dfi_ras_n_o),
    .dfi_cas_n_o(dfi_cas_n_o), .dfi_we_n_o(dfi_we_n_o), .dfi_reset_n_o(dfi_reset_n_o),
    .dfi_odt_o(dfi_odt_o), .dfi_wrdata_en_o(dfi_wrdata_en_o), .dfi_wrdata_o(dfi_wrdata_o),
    .dfi_wrdata_mask_o(dfi_wrdata_mask_o), .dfi_rddata_en_o(dfi_rddata_en_o),
    .dfi_rddata_i(dfi_rddata_i), .dfi_rddata_valid_i(dfi_rddata_valid_i), .error_o(error_o)
  );

  int total = 0;
  int bad = 0;
  rec_t sb[$];
  bit run = 1'b0;

  // Behavioural model state
  cmd_t m_cmd;
  logic m_wren;
  logic [WD-1:0] m_wd;
  logic [MW-1:0] m_mask;
  int m_out = 0;
  int slot = 0;
  bit rd_at[int];
  bit m_sticky = 1'b0;

  localparam logic [63:0] RESET_DFI = {3'd0, 16'd0, 7'b0111100, 1'b0, 32'd0, 4'd0, 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_dfi();
    return {dfi_bank_o, dfi_address_o, dfi_cke_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o,
            dfi_we_n_o, dfi_reset_n_o, dfi_odt_o, dfi_wrdata_en_o, dfi_wrdata_o,
            dfi_wrdata_mask_o, dfi_rddata_en_o};
  endfunction

  function automatic logic [25:0] mk(input logic [2:0] b, input logic [15:0] a, input logic cke,
                                     input logic cs, input logic ras, input logic cas, input logic we);
    cmd_t c;
    c = '{bank: b, addr: a, cke: cke, cs_n: cs, ras_n: ras, cas_n: cas, we_n: we,
          reset_n: 1'b1, odt: 1'b0};
    return c;
  endfunction

  // One DFI slot: apply inputs in the phase-0 cycle, predict, then noise for the rest of the slot
  task automatic do_slot(input logic cv, input logic [25:0] cd, input logic wv,
                         input logic [WD+MW-1:0] wd, input logic rv, input logic rdy,
                         input logic [WD-1:0] rdat);
    rec_t r;
    cmd_t c;
    bit is_rd, stl, cy, err, rden;
    cmd_v_i = cv; cmd_data_i = cd; wr_v_i = wv; wr_data_i = wd;
    dfi_rddata_valid_i = rv; rd_ready_i = rdy; dfi_rddata_i = rdat;
    c = cd;
    is_rd = (c.cs_n == 1'b0) && c.ras_n && !c.cas_n && c.we_n;
    stl = (m_out == 255) && is_rd;
    cy = cv && !stl;
    if (cy) m_cmd = c;
    else begin m_cmd.cs_n = 1'b1; m_cmd.ras_n = 1'b1; m_cmd.cas_n = 1'b1; m_cmd.we_n = 1'b1; end
    m_wren = wv;
    if (wv) {m_wd, m_mask} = wd;
    if (cy && is_rd) rd_at[slot + D] = 1'b1;
    rden = rd_at.exists(slot);
    err = rv && (!rdy || m_out == 0);
    if (cy && is_rd && !rv) m_out++;
    else if (rv && !(cy && is_rd) && m_out > 0) m_out--;
    m_sticky = m_sticky | err;
    r.cy = cy; r.wy = wv; r.rv = rv; r.rdat = rdat;
    r.dfi = {m_cmd, m_wren, m_wd, m_mask, rden};
    r.e1 = STICKY ? m_sticky : err;
    r.erest = STICKY ? m_sticky : 1'b0;
    sb.push_back(r);
    slot++;
    repeat (CR - 1) begin
      @(posedge clk); #1;
      cmd_v_i = 1'($urandom); cmd_data_i = 26'($urandom); wr_v_i = 1'($urandom);
      wr_data_i = {$urandom, 4'($urandom)}; dfi_rddata_valid_i = 1'($urandom);
      rd_ready_i = 1'($urandom); dfi_rddata_i = $urandom;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: own cycle count; phase-0 handshakes vs. scoreboard, DFI hold across the slot
  int mc = 0;
  int mk_ph;
  rec_t cur, nxt;
  bit have = 1'b0;
  always @(negedge clk) begin
    if (run) begin
      mk_ph = mc % CR;
      if (mk_ph == 0) begin
        if (have) begin
          check("dfi_last_cycle", dut_dfi(), cur.dfi);
          check("err_last_cycle", 64'(error_o), 64'(cur.erest));
        end
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: got no expected entry, required one at cycle %0d", mc);
        end else begin
          nxt = sb.pop_front();
          check("cmd_yumi", 64'(cmd_yumi_o), 64'(nxt.cy));
          check("wr_yumi", 64'(wr_yumi_o), 64'(nxt.wy));
          check("rd_v", 64'(rd_v_o), 64'(nxt.rv));
          if (nxt.rv) check("rd_data", 64'(rd_data_o), 64'(nxt.rdat));
          cur = nxt; have = 1'b1;
        end
      end else begin
        check("cmd_yumi_idle", 64'(cmd_yumi_o), 64'd0);
        check("wr_yumi_idle", 64'(wr_yumi_o), 64'd0);
        check("rd_v_idle", 64'(rd_v_o), 64'd0);
        check("dfi_slot", dut_dfi(), cur.dfi);
        check("error", 64'(error_o), 64'((mk_ph == 1) ? cur.e1 : cur.erest));
      end
      mc++;
    end
  end

  initial begin
    logic [25:0] rd_cmd, act_cmd;
    int k;
    bit rv;
    m_cmd = RESET_DFI[63:38];
    m_wren = 1'b0; m_wd = '0; m_mask = '0;
    rd_cmd  = mk(3'd1, 16'h0040, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    act_cmd = mk(3'd3, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset with requests pending: no handshakes, DFI at reset values
    cmd_v_i = 1'b1; cmd_data_i = act_cmd; wr_v_i = 1'b1; dfi_rddata_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_yumi", 64'(cmd_yumi_o), 64'd0);
    check("rst_wr_yumi", 64'(wr_yumi_o), 64'd0);
    check("rst_rd_v", 64'(rd_v_o), 64'd0);
    check("rst_dfi", dut_dfi(), RESET_DFI);
    check("rst_error", 64'(error_o), 64'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    run = 1'b1;

    // ACT word, then NOP slot with cke held
    do_slot(1, act_cmd, 0, '0, 0, 1, '0);
    do_slot(0, '0, 0, '0, 0, 1, '0);
    // Read: rddata_en two slots later
    do_slot(1, rd_cmd, 0, '0, 0, 1, '0);
    repeat (3) do_slot(0, '0, 0, '0, 0, 1, '0);
    // Return with read FIFO not ready: dropped, error
    do_slot(0, '0, 0, '0, 1, 0, 32'hCAFE_0001);
    do_slot(0, '0, 0, '0, 0, 1, '0);
    // Return with nothing outstanding: error, count stays 0
    do_slot(0, '0, 0, '0, 1, 1, 32'hCAFE_0002);
    do_slot(0, '0, 0, '0, 0, 1, '0);
    // Back-to-back writes A, B then idle with data held
    do_slot(0, '0, 1, {32'hAAAA_0001, 4'h5}, 0, 1, '0);
    do_slot(0, '0, 1, {32'hBBBB_0002, 4'hA}, 0, 1, '0);
    do_slot(0, '0, 0, '0, 0, 1, '0);

    // Randomised traffic
    for (int i = 0; i < 200; i++) begin
      logic [25:0] c;
      k = $urandom_range(0, 5);
      case (k)
        0: c = 26'($urandom);
        1: c = mk(3'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
        2: c = mk(3'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        3: c = mk(3'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        4: c = mk(3'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        default: c = 26'($urandom);
      endcase
      rv = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      do_slot(1'($urandom_range(0, 3) != 0), c, 1'($urandom),
              {$urandom, 4'($urandom)}, rv, 1'($urandom_range(0, 7) != 0), $urandom);
    end

    // Drain, then fill to 255 outstanding and exercise the stall
    for (int i = 0; i < 300 && m_out > 0; i++)
      do_slot(0, '0, 0, '0, 1, 1, $urandom);
    for (int i = 0; i < 255; i++)
      do_slot(1, rd_cmd, 0, '0, 0, 1, '0);
    repeat (3) do_slot(1, rd_cmd, 0, '0, 0, 1, '0);
    do_slot(1, act_cmd, 0, '0, 0, 1, '0);
    do_slot(1, rd_cmd, 0, '0, 1, 1, 32'h1234_5678);
    do_slot(1, rd_cmd, 1, {32'hDEAD_BEEF, 4'h3}, 0, 1, '0);
    repeat (3) do_slot(0, '0, 0, '0, 0, 1, '0);

    // Reset asserted in a phase-0 cycle with requests pending
    run = 1'b0;
    cmd_v_i = 1'b1; cmd_data_i = act_cmd; wr_v_i = 1'b1; dfi_rddata_valid_i = 1'b1;
    reset_i = 1'b1;
    @(negedge clk);
    check("rst2_cmd_yumi", 64'(cmd_yumi_o), 64'd0);
    check("rst2_wr_yumi", 64'(wr_yumi_o), 64'd0);
    check("rst2_rd_v", 64'(rd_v_o), 64'd0);
    @(posedge clk); #1;
    check("rst2_dfi", dut_dfi(), RESET_DFI);
    check("rst2_error", 64'(error_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
